// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from a show-ahead FIFO and shifts them out
// as start/8 data/optional parity/1-2 stop frames at a programmable bit period.
module uart_tx_engine #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned DIVW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIVW-1:0]  div_i,
  input  logic             par_en_i,
  input  logic             par_odd_i,
  input  logic             stop2_i,
  input  logic [DATAW-1:0] fifo_dat_i,
  input  logic             fifo_empty_i,
  output logic             fifo_re_o,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int unsigned IdxW = (DATAW > 1) ? $clog2(DATAW) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATAW - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [DIVW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic [DATAW-1:0] shift_q, shift_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic             bit_end;
  logic             launch;
  logic             load;

  assign bit_end = (baud_cnt_q == div_q);
  // Reset also suppresses the pop so no byte is lost while the engine is held.
  assign launch  = en_i & ~fifo_empty_i & ~rst_i;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    load       = 1'b0;

    if (state_q != StIdle) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIVW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (launch) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == LastIdx) begin
            stop_idx_d = 1'b0;
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (launch) begin
            // Back-to-back: next start bit follows the last stop cycle directly.
            load = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      state_d    = StStart;
      baud_cnt_d = '0;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      shift_d    = fifo_dat_i;
      div_d      = div_i;
      par_en_d   = par_en_i;
      par_bit_d  = par_odd_i ? ~^fifo_dat_i : ^fifo_dat_i;
      stop2_d    = stop2_i;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_re_o = load;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: FIFO model feeds bytes, expected frames are queued at
// each pop and checked cycle-by-cycle against the line by a monitor.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div = 16'd0;
  logic        par_en = 1'b0;
  logic        par_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic [7:0]  fifo_dat = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_re;
  logic        tx;
  logic        busy;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] push_req[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_cyc = 0;
  int pops = 0;
  int frames = 0;
  int last_gap = 0;
  bit in_frame = 1'b0;

  always #5 clk = ~clk;

  uart_tx_engine #(
    .DATAW(8),
    .DIVW (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .div_i       (div),
    .par_en_i    (par_en),
    .par_odd_i   (par_odd),
    .stop2_i     (stop2),
    .fifo_dat_i  (fifo_dat),
    .fifo_empty_i(fifo_empty),
    .fifo_re_o   (fifo_re),
    .tx_o        (tx),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic pe, input logic po,
                                        input logic s2, input logic [15:0] dv);
    frame_t f;
    int     n;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
    n = 9;
    if (pe) begin
      // Odd parity: total ones incl. parity bit is odd.
      f.bits[9] = po ? (($countones(d) % 2) == 0) : (($countones(d) % 2) == 1);
      n = 10;
    end
    f.nbits = n + (s2 ? 2 : 1);
    f.div   = int'(dv);
    return f;
  endfunction

  // FIFO model: pop on strobe, queue the expected frame with the config seen at the pop.
  always @(posedge clk) begin
    if (fifo_re) begin
      if (fifo_q.size() == 0) begin
        check_eq("re_while_empty", 32'd1, 32'd0);
      end else begin
        exp_q.push_back(make_frame(fifo_q[0], par_en, par_odd, stop2, div));
        void'(fifo_q.pop_front());
        pops++;
        pop_cyc = cyc;
      end
    end
    while (push_req.size() > 0) fifo_q.push_back(push_req.pop_front());
    fifo_dat   <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    fifo_empty <= (fifo_q.size() == 0);
    cyc++;
  end

  // Line monitor: every cycle of every frame is compared against the scoreboard.
  initial begin : monitor
    int     gap;
    frame_t f;
    bit     abort;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gap = 0;
        continue;
      end
      if (tx === 1'b0) begin
        frames++;
        last_gap = gap;
        gap      = 0;
        in_frame = 1'b1;
        abort    = 1'b0;
        check_eq("start_latency", 32'(cyc - pop_cyc), 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          for (int b = 0; b < f.nbits && !abort; b++) begin
            for (int c = 0; c <= f.div && !abort; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst) begin
                abort = 1'b1;
              end else begin
                check_eq($sformatf("tx_bit%0d", b), {31'd0, tx}, {31'd0, f.bits[b]});
                check_eq("busy_in_frame", {31'd0, busy}, 32'd1);
              end
            end
          end
        end
        in_frame = 1'b0;
      end else begin
        gap++;
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic push(input logic [7:0] d);
    push_req.push_back(d);
  endtask

  task automatic wait_pops(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pops >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("pop_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !in_frame && busy === 1'b0 &&
          (fifo_q.size() == 0 || !en)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("idle_wait", {31'd0, ok}, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int p0;
    int f0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_re", {31'd0, fifo_re}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 at div 3; format/divisor changes mid-frame must not affect it
    div = 16'd3;
    en  = 1'b1;
    push(8'h55);
    wait_pops(1, 20);
    div    = 16'd7;
    par_en = 1'b1;
    stop2  = 1'b1;
    wait_idle(200);
    check_eq("t1_pops", 32'(pops), 32'd1);
    check_eq("t1_frames", 32'(frames), 32'd1);
    par_en = 1'b0;
    stop2  = 1'b0;

    // Back-to-back at div 0: no idle gap between frames
    div = 16'd0;
    en  = 1'b0;
    push(8'hA3);
    push(8'h0F);
    repeat (3) @(negedge clk);
    f0 = frames;
    en = 1'b1;
    wait_idle(100);
    check_eq("t2_frames", 32'(frames - f0), 32'd2);
    check_eq("t2_gap", 32'(last_gap), 32'd0);
    check_eq("t2_pops", 32'(pops), 32'd3);

    // Parity odd/even, then parity with two stop bits
    div     = 16'd1;
    par_en  = 1'b1;
    par_odd = 1'b1;
    push(8'h01);
    wait_idle(100);
    par_odd = 1'b0;
    push(8'h01);
    wait_idle(100);
    stop2 = 1'b1;
    push(8'hE6);
    wait_idle(100);
    par_en = 1'b0;
    stop2  = 1'b0;
    check_eq("t3_frames", 32'(frames), 32'd6);

    // Empty FIFO with enable high: nothing happens
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("t4_re", {31'd0, fifo_re}, 32'd0);
      check_eq("t4_tx", {31'd0, tx}, 32'd1);
      check_eq("t4_busy", {31'd0, busy}, 32'd0);
    end

    // Enable dropped mid-frame with two bytes queued
    div = 16'd2;
    en  = 1'b0;
    push(8'h3C);
    push(8'hC3);
    repeat (3) @(negedge clk);
    p0 = pops;
    en = 1'b1;
    wait_pops(p0 + 1, 20);
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_idle(200);
    repeat (20) @(negedge clk);
    check_eq("t5_pops", 32'(pops - p0), 32'd1);
    check_eq("t5_fifo_left", 32'(fifo_q.size()), 32'd1);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);

    // Reset mid-DATA: line released asynchronously, next byte sent cleanly
    div = 16'd3;
    push(8'h96);
    repeat (3) @(negedge clk);
    p0 = pops;
    f0 = frames;
    en = 1'b1;
    wait_pops(p0 + 1, 20);
    repeat (12) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_async_tx", {31'd0, tx}, 32'd1);
    check_eq("t6_async_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_rst_re", {31'd0, fifo_re}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle(200);
    check_eq("t6_pops", 32'(pops - p0), 32'd2);
    check_eq("t6_frames", 32'(frames - f0), 32'd2);
    check_eq("t6_fifo_left", 32'(fifo_q.size()), 32'd0);
    check_eq("end_exp_empty", 32'(exp_q.size()), 32'd0);
    check_eq("end_pops_frames", 32'(pops), 32'(frames));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
